// File: rtl/alu_dispatch.sv
// Serial issue/writeback controller for a combinational ALU with an 8x32 register file.
// Optional load-immediate support is enabled by defining ALU_DISPATCH_LOADI_EN.
module alu_dispatch #(
  parameter int         REGS     = 8,
  parameter logic [4:0] LOADI_OP = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs1,
  input  logic [2:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_flag,
  output logic        done,
  output logic        flag,
  output logic        err,
  input  logic        err_clr,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [REGS-1:0][31:0]  rf_q, rf_d;
  logic [2:0]             rd_q, rd_d;
  logic [31:0]            a_q, a_d, b_q, b_d;
  logic [4:0]             op_q, op_d;
  logic                   rdy_q, rdy_d, done_q, done_d;
  logic                   flag_q, flag_d, err_q, err_d;
  logic                   is_alu, is_ldi, err_set;

  assign is_alu = (in_op <= 5'd3);
`ifdef ALU_DISPATCH_LOADI_EN
  assign is_ldi = (in_op == LOADI_OP);
`else
  logic unused_imm;
  assign is_ldi     = 1'b0;
  assign unused_imm = ^{in_imm, LOADI_OP};
`endif

  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    flag_d  = flag_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_alu) begin
            a_d     = rf_q[in_rs1];
            b_d     = rf_q[in_rs2];
            op_d    = in_op;
            rd_d    = in_rd;
            rdy_d   = 1'b0;
            state_d = EXEC;
          end else if (is_ldi) begin
            rf_d[in_rd] = in_imm;
            rdy_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      EXEC: begin
        rf_d[rd_q] = alu_c;
        flag_d     = alu_flag;
        done_d     = 1'b1;
        state_d    = DONE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
    // r0 is hardwired to zero; any write to it is dropped here
    rf_d[0] = '0;
    err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rf_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = rdy_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign done     = done_q;
  assign flag     = flag_q;
  assign err      = err_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: stimulus pushes expected retirements, a monitor checks them on done.
module tb_alu_dispatch;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_op;
  logic        alu_flag, done, flag, err, err_clr;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        flg;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_flag(alu_flag),
    .done(done), .flag(flag), .err(err), .err_clr(err_clr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always_comb begin
    case (alu_op)
      5'd0:    alu_c = alu_a + alu_b;
      5'd1:    alu_c = alu_a - alu_b;
      5'd2:    alu_c = alu_a << alu_b;
      5'd3:    alu_c = alu_a >> alu_b;
      default: alu_c = '0;
    endcase
    alu_flag = (alu_c == 32'd0);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", dbg_data, e.data);
        chk("wb_flag", {31'd0, flag}, {31'd0, e.flg});
        chk("done_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] imm, input bit exp_done,
                       input logic [31:0] exp_data, input logic exp_flag, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    dbg_addr = rd;
    if (exp_done) sb.push_back('{exp_data, exp_flag, cyc, lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    if (exp_done && lat == 2) chk("exec_alu_op", {27'd0, alu_op}, {27'd0, op});
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("retire_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; err_clr = 1'b0; dbg_addr = 3'd3;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dbg_r3", dbg_data, 32'd0);
    rst_n = 1'b1;

`ifdef ALU_DISPATCH_LOADI_EN
    issue(5'd31, 3'd1, 3'd0, 3'd0, 32'd5, 1, 32'd5, 1'b0, 1);
    issue(5'd31, 3'd2, 3'd0, 3'd0, 32'd3, 1, 32'd3, 1'b0, 1);
    issue(5'd0,  3'd3, 3'd1, 3'd2, 32'd0, 1, 32'd8, 1'b0, 2);
    chk("done_count_3", done_cnt, 3);
    issue(5'd31, 3'd4, 3'd0, 3'd0, 32'd3, 1, 32'd3, 1'b0, 1);
    issue(5'd1,  3'd5, 3'd2, 3'd4, 32'd0, 1, 32'd0, 1'b1, 2);
    issue(5'd1,  3'd6, 3'd2, 3'd1, 32'd0, 1, 32'hFFFF_FFFE, 1'b0, 2);
    issue(5'd31, 3'd0, 3'd0, 3'd0, 32'hDEAD, 1, 32'd0, 1'b0, 1);
    issue(5'd0,  3'd7, 3'd0, 3'd1, 32'd0, 1, 32'd5, 1'b0, 2);
    issue(5'd2,  3'd3, 3'd1, 3'd2, 32'd0, 1, 32'd40, 1'b0, 2);
    issue(5'd3,  3'd5, 3'd1, 3'd2, 32'd0, 1, 32'd0, 1'b1, 2);
`else
    issue(5'd0,  3'd3, 3'd0, 3'd0, 32'd0, 1, 32'd0, 1'b1, 2);
    issue(5'd31, 3'd1, 3'd0, 3'd0, 32'd5, 0, 32'd0, 1'b0, 0);
    chk("noldi_err", {31'd0, err}, 32'd1);
    dbg_addr = 3'd1;
    #1 chk("noldi_r1_unchanged", dbg_data, 32'd0);
    chk("noldi_no_done", done_cnt, 1);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    issue(5'd1,  3'd4, 3'd1, 3'd2, 32'd0, 1, 32'd0, 1'b1, 2);
    issue(5'd2,  3'd5, 3'd6, 3'd7, 32'd0, 1, 32'd0, 1'b1, 2);
`endif

    dc = done_cnt;
    issue(5'd7, 3'd2, 3'd1, 3'd1, 32'd0, 0, 32'd0, 1'b0, 0);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("err_clr", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    issue(5'd9, 3'd2, 3'd1, 3'd1, 32'd0, 0, 32'd0, 1'b0, 0);
    chk("illegal_beats_clr", {31'd0, err}, 32'd1);
    chk("illegal_no_done", done_cnt, dc);

    // Abort an ADD while it is in EXEC
    dc = done_cnt;
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'd0; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2; dbg_addr = 3'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("abort_in_exec", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_alu_b", alu_b, 32'd0);
    chk("abort_alu_op", {27'd0, alu_op}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_flag", {31'd0, flag}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_r3", dbg_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Sequential issue/writeback controller that drives the combinational ALU. It accepts one instruction at a time over a valid/ready handshake and holds a small register file. It presents the operands and opcode to the ALU, captures the result and flag, writes the result back, and signals completion. It sits between the instruction source and the ALU, on the opposite side of the ALU's A/B/instr → C/flag interface.

## Interface
Parameters:
- REGS, 8: number of 32-bit registers; must be 8 (3-bit register fields).
- LOADI_OP, 31: opcode value decoded as load-immediate.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  dispatcher can accept an instruction.
- in_op  in  5  opcode: 0 add, 1 sub, 2 shift-left, 3 shift-right, LOADI_OP load-immediate.
- in_rd, in_rs1, in_rs2  in  3 each  destination and source register indices.
- in_imm  in  32  immediate, used only by load-immediate.
- alu_a, alu_b  out  32  registered operands to the ALU.
- alu_op  out  5  registered opcode to the ALU.
- alu_c  in  32  ALU result; combinational from alu_a/alu_b/alu_op.
- alu_flag  in  1  ALU flag.
- done  out  1  one-cycle pulse when an instruction retires.
- flag  out  1  last captured ALU flag.
- err  out  1  sticky illegal-opcode indicator.
- err_clr  in  1  synchronous clear of err.
- dbg_addr  in  3  debug read index.
- dbg_data  out  32  combinational read of register dbg_addr.

## Operation
- Register file r0..r7, 32 bits each. r0 always reads 0; writes to r0 are discarded. r1..r7 reset to 0.
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid:
  - Ops 0–3: load alu_a←r[rs1], alu_b←r[rs2], alu_op←in_op, latch rd, go to EXEC.
  - LOADI_OP: write in_imm to r[rd], go to DONE. ALU outputs are unchanged and flag is unchanged.
  - Any other opcode: set err, discard the instruction, stay in IDLE. No done pulse.
- EXEC: in_ready=0. ALU inputs are stable for the whole cycle. At the closing edge: r[rd]←alu_c, flag←alu_flag. Go to DONE.
- DONE: in_ready=0, done=1 for exactly this cycle. Go to IDLE.
- rs1/rs2 reads return the value written by the previous instruction; the dispatcher is strictly serial, so there are no hazards.
- The dispatcher passes operands at full 32-bit width and does no arithmetic. Shift-amount interpretation and wrap-around belong to the ALU. The 32-bit result wraps (no carry out).
- err_clr has priority below a same-cycle illegal opcode: if both occur in one cycle, err stays 1.
- An rst_n assertion mid-instruction aborts it: no writeback, no done pulse, state returns to IDLE.

## Timing
- Reset values: in_ready=1 (IDLE), alu_a=0, alu_b=0, alu_op=0, done=0, flag=0, err=0, all registers 0.
- ALU op accepted at edge T. alu_* valid from T to T+1. Writeback at edge T+1. done high T+1 to T+2. in_ready high again from T+2.
- Throughput is one ALU instruction per 3 cycles and one load-immediate per 2 cycles.
- Load-immediate accepted at T: register written at T, done high T to T+1.
- dbg_data reflects a write from the cycle after the writing edge.

## Configuration
- ALU_DISPATCH_LOADI_EN defined: load-immediate is supported as described above.
- ALU_DISPATCH_LOADI_EN undefined:
  - in_imm is ignored and LOADI_OP is treated as illegal (sets err, no done).
  - Registers can only hold values produced by the ALU, so all stay 0 unless the bench preloads them hierarchically.

## Test plan
The bench models the ALU combinationally: op0 A+B, op1 A−B, op2 A<<B, op3 A>>B; flag = (C==0).
- Reset release, then LOADI r1=5, LOADI r2=3, ADD r3=r1+r2 → dbg_data(r3)=8, flag=0, done seen 3 times, ADD done exactly 2 cycles after accept.
- Exercise sub and the flag, with LOADI r4=3: SUB r5=r2−r4 → r5=0, flag=1. SUB r6=r2−r1 → r6=0xFFFFFFFE, flag=0.
- Exercise r0 handling: LOADI r0=0xDEAD → dbg_data(r0)=0. ADD r7=r0+r1 → r7=5.
- Drive illegal op 7 → err=1, no done, in_ready stays 1. Pulse err_clr → err=0. Illegal op and err_clr in the same cycle → err=1.
- Assert rst_n low during EXEC of ADD r3 → no done, r3=0, every output at its reset value.
- Build without ALU_DISPATCH_LOADI_EN: op 31 → err=1, target register unchanged.
